// File: rtl/msrv32_wb_queue_unit_if.sv
// Bus bundle for msrv32_wb_queue_unit.
// Purpose : groups the write-back request, register-file write port,
//           forwarding lookup and status signals of the buffered write-back stage.
// Modports: master - the core side; it drives requests, the rf ready and lookup addresses.
//           slave  - the queue unit itself.
// Signals : flush_in, wb_valid_in/wb_ready_out, wb_mux_sel_in, wb_src_bus_in,
//           rd_addr_in, rf_wr_en_in, rf_valid_out/rf_ready_in, rf_rd_addr_out,
//           rf_wr_en_out, rf_wr_data_out, rs1/rs2_addr_in, fwd1/2_hit_out,
//           fwd1/2_data_out, count_out.
interface msrv32_wb_queue_unit_if #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 8,
  parameter int SEL_W   = 3,
  parameter int DEPTH   = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                    flush_in;
  logic                    wb_valid_in;
  logic                    wb_ready_out;
  logic [SEL_W-1:0]        wb_mux_sel_in;
  logic [NUM_SRC*XLEN-1:0] wb_src_bus_in;
  logic [4:0]              rd_addr_in;
  logic                    rf_wr_en_in;
  logic                    rf_valid_out;
  logic                    rf_ready_in;
  logic [4:0]              rf_rd_addr_out;
  logic                    rf_wr_en_out;
  logic [XLEN-1:0]         rf_wr_data_out;
  logic [4:0]              rs1_addr_in;
  logic [4:0]              rs2_addr_in;
  logic                    fwd1_hit_out;
  logic                    fwd2_hit_out;
  logic [XLEN-1:0]         fwd1_data_out;
  logic [XLEN-1:0]         fwd2_data_out;
  logic [CNT_W-1:0]        count_out;

  modport master (
    output flush_in, wb_valid_in, wb_mux_sel_in, wb_src_bus_in, rd_addr_in,
           rf_wr_en_in, rf_ready_in, rs1_addr_in, rs2_addr_in,
    input  wb_ready_out, rf_valid_out, rf_rd_addr_out, rf_wr_en_out,
           rf_wr_data_out, fwd1_hit_out, fwd2_hit_out, fwd1_data_out,
           fwd2_data_out, count_out
  );

  modport slave (
    input  flush_in, wb_valid_in, wb_mux_sel_in, wb_src_bus_in, rd_addr_in,
           rf_wr_en_in, rf_ready_in, rs1_addr_in, rs2_addr_in,
    output wb_ready_out, rf_valid_out, rf_rd_addr_out, rf_wr_en_out,
           rf_wr_data_out, fwd1_hit_out, fwd2_hit_out, fwd1_data_out,
           fwd2_data_out, count_out
  );
endinterface

// File: rtl/msrv32_wb_queue_unit.sv
// msrv32_wb_queue_unit
// Purpose : buffered write-back stage. It selects one of NUM_SRC result buses
//           for each instruction. It queues (rd, wr_en, data) in a DEPTH-entry
//           FIFO in front of the register-file write port. It also forwards
//           rs1/rs2 from queued entries and supports a pipeline flush.
// Ports   : ms_riscv32_mp_clk_in   - core clock, rising edge.
//           ms_riscv32_mp_rst_n_in - synchronous reset, active low.
//           wb (slave modport)     - request, register-file, forwarding and
//                                    status signals.
// The interface instance must be built with the same XLEN/NUM_SRC/SEL_W/DEPTH.
module msrv32_wb_queue_unit #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 8,
  parameter int SEL_W   = 3,
  parameter int DEPTH   = 2
) (
  input  logic                  ms_riscv32_mp_clk_in,
  input  logic                  ms_riscv32_mp_rst_n_in,
  msrv32_wb_queue_unit_if.slave wb
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Entry storage. It is kept in flops, not RAM, because forwarding has to
  // inspect every entry in parallel.
  logic [4:0]       rd_mem_reg   [DEPTH];
  logic             we_mem_reg   [DEPTH];
  logic [XLEN-1:0]  data_mem_reg [DEPTH];

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [XLEN-1:0]  src_arr [NUM_SRC];
  logic [XLEN-1:0]  sel_data;
  logic [XLEN-1:0]  push_data;
  logic             push_we;
  logic             rf_valid;
  logic             pop;
  logic             ready;
  logic             push;

  // Pointers wrap explicitly at DEPTH-1, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- source select ----------------
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_arr[gi] = wb.wb_src_bus_in[gi*XLEN +: XLEN];
  end

  // An unmatched select value (>= NUM_SRC) falls back to source 0, the ALU.
  always_comb begin
    sel_data = src_arr[0];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (wb.wb_mux_sel_in == SEL_W'(k)) sel_data = src_arr[k];
    end
  end

  // A write to x0 is queued as a no-op entry. It keeps its FIFO slot but never
  // writes the register file and never forwards.
  assign push_we   = wb.rf_wr_en_in && (wb.rd_addr_in != 5'd0);
  assign push_data = (wb.rd_addr_in == 5'd0) ? '0 : sel_data;

  // ---------------- handshake ----------------
  assign rf_valid = (count_reg != '0);
  assign pop      = rf_valid && wb.rf_ready_in;
  // A full queue still accepts when the head leaves in the same cycle.
  assign ready    = !wb.flush_in && ((count_reg < CNT_W'(DEPTH)) || pop);
  assign push     = wb.wb_valid_in && ready;

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_reg[i]   <= '0;
        we_mem_reg[i]   <= 1'b0;
        data_mem_reg[i] <= '0;
      end
    end else if (wb.flush_in) begin
      // push is already held low by ready. A head popped this cycle has been
      // seen by the register file, so dropping it here loses nothing.
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      if (push) begin
        rd_mem_reg[wr_ptr_reg]   <= wb.rd_addr_in;
        we_mem_reg[wr_ptr_reg]   <= push_we;
        data_mem_reg[wr_ptr_reg] <= push_data;
      end
    end
  end

  // ---------------- head outputs ----------------
  // The head slot is only overwritten after it has been popped, so these
  // outputs stay stable while the register file stalls.
  assign wb.wb_ready_out   = ready;
  assign wb.rf_valid_out   = rf_valid;
  assign wb.rf_rd_addr_out = rf_valid ? rd_mem_reg[rd_ptr_reg]   : 5'd0;
  assign wb.rf_wr_en_out   = rf_valid ? we_mem_reg[rd_ptr_reg]   : 1'b0;
  assign wb.rf_wr_data_out = rf_valid ? data_mem_reg[rd_ptr_reg] : '0;
  assign wb.count_out      = count_reg;

  // ---------------- forwarding ----------------
  // age_idx[a] is the slot that holds the a-th oldest entry. age_live marks
  // which ages are occupied.
  logic [PTR_W-1:0] age_idx  [DEPTH];
  logic             age_live [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [PTR_W:0] sum;
    assign sum           = {1'b0, rd_ptr_reg} + (PTR_W+1)'(gi);
    assign age_idx[gi]   = (sum >= (PTR_W+1)'(DEPTH)) ?
                           PTR_W'(sum - (PTR_W+1)'(DEPTH)) : sum[PTR_W-1:0];
    assign age_live[gi]  = (CNT_W'(gi) < count_reg);
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [4:0]      rs;
    logic            hit;
    logic [XLEN-1:0] data;

    assign rs = (gi == 0) ? wb.rs1_addr_in : wb.rs2_addr_in;

    // Entries are scanned from oldest to youngest. A later match overrides
    // an earlier one, so the youngest match wins.
    always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int a = 0; a < DEPTH; a++) begin
        if (age_live[a] && we_mem_reg[age_idx[a]] &&
            rd_mem_reg[age_idx[a]] == rs && rs != 5'd0) begin
          hit  = 1'b1;
          data = data_mem_reg[age_idx[a]];
        end
      end
    end
  end

  assign wb.fwd1_hit_out  = g_fwd[0].hit;
  assign wb.fwd1_data_out = g_fwd[0].data;
  assign wb.fwd2_hit_out  = g_fwd[1].hit;
  assign wb.fwd2_data_out = g_fwd[1].data;
endmodule

// File: tb/tb_msrv32_wb_queue_unit.sv
module tb_msrv32_wb_queue_unit;
  localparam int XLEN    = 32;
  localparam int NUM_SRC = 8;
  localparam int SEL_W   = 4;
  localparam int DEPTH   = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  msrv32_wb_queue_unit_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DEPTH(DEPTH)) bus ();

  msrv32_wb_queue_unit #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .wb                     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain queue of the entries that the register file
  // has not yet taken.
  ent_t        mq[$];
  logic [31:0] src_w [NUM_SRC];

  task automatic set_src();
    for (int k = 0; k < NUM_SRC; k++) bus.wb_src_bus_in[k*32 +: 32] = src_w[k];
  endtask

  task automatic rand_src();
    for (int k = 0; k < NUM_SRC; k++) src_w[k] = $urandom;
    set_src();
  endtask

  function automatic bit m_ready();
    return !bus.flush_in && (mq.size() < DEPTH || (mq.size() != 0 && bus.rf_ready_in));
  endfunction

  function automatic ent_t m_entry();
    ent_t e;
    int   s;
    s = int'(bus.wb_mux_sel_in);
    e.rd   = bus.rd_addr_in;
    e.we   = bus.rf_wr_en_in && bus.rd_addr_in != 0;
    e.data = (bus.rd_addr_in == 0) ? 32'h0 : ((s < NUM_SRC) ? src_w[s] : src_w[0]);
    return e;
  endfunction

  function automatic ent_t m_head();
    ent_t e;
    e = '0;
    if (mq.size() != 0) e = mq[0];
    return e;
  endfunction

  // Returns {hit, data}. The search runs from the youngest entry to the oldest.
  function automatic logic [32:0] m_fwd(input logic [4:0] rs);
    if (rs != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].we && mq[i].rd == rs) return {1'b1, mq[i].data};
    end
    return 33'h0;
  endfunction

  // Advances one clock and applies the same clock edge to the model.
  task automatic tick();
    bit   acc, pop;
    ent_t e;
    pop = rst_n && mq.size() != 0 && bus.rf_ready_in;
    acc = rst_n && bus.wb_valid_in && m_ready();
    e   = m_entry();
    @(posedge clk);
    if (!rst_n) mq.delete();
    else begin
      if (pop) begin
        $display("  [%0t] write rd=%0d we=%0b data=%h", $time, mq[0].rd, mq[0].we, mq[0].data);
        void'(mq.pop_front());
      end
      if (bus.flush_in) begin
        if (mq.size() != 0) $display("  [%0t] flush drops %0d entries", $time, mq.size());
        mq.delete();
      end else if (acc) begin
        $display("  [%0t] accept rd=%0d we=%0b data=%h", $time, e.rd, e.we, e.data);
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush_in = 0; bus.wb_valid_in = 0; bus.wb_mux_sel_in = '0;
    bus.rd_addr_in = 0; bus.rf_wr_en_in = 0; bus.rf_ready_in = 0;
    bus.rs1_addr_in = 0; bus.rs2_addr_in = 0;
  endtask

  task automatic drain();
    bus.wb_valid_in = 0; bus.flush_in = 0; bus.rf_ready_in = 1;
    for (int i = 0; i < 10 && mq.size() != 0; i++) tick();
  endtask

  task automatic push_one(input logic [4:0] rd, input logic [31:0] d);
    src_w[0] = d; set_src();
    bus.wb_mux_sel_in = 0; bus.rd_addr_in = rd; bus.rf_wr_en_in = 1; bus.wb_valid_in = 1;
    tick();
    bus.wb_valid_in = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); rand_src();
    rst_n = 0; tick(); tick(); #1;
    n_checks++; if (bus.count_out !== 0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count_out); end
    n_checks++; if (bus.rf_valid_out !== 0 || bus.rf_rd_addr_out !== 0 || bus.rf_wr_en_out !== 0 || bus.rf_wr_data_out !== 0) begin
      n_fail++; $display("FAIL reset_head: got v=%b rd=%0d we=%b d=%h expected all 0", bus.rf_valid_out, bus.rf_rd_addr_out, bus.rf_wr_en_out, bus.rf_wr_data_out); end
    n_checks++; if (bus.fwd1_hit_out !== 0 || bus.fwd2_hit_out !== 0 || bus.fwd1_data_out !== 0 || bus.fwd2_data_out !== 0) begin
      n_fail++; $display("FAIL reset_fwd: got h1=%b h2=%b d1=%h d2=%h expected all 0", bus.fwd1_hit_out, bus.fwd2_hit_out, bus.fwd1_data_out, bus.fwd2_data_out); end
    n_checks++; if (bus.wb_ready_out !== 1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.wb_ready_out); end
    rst_n = 1;
  endtask

  task automatic test_select();
    logic [31:0] exp_src0;
    rand_src();
    src_w[5] = 32'h0000_1004; src_w[7] = 32'h0; set_src();
    bus.rf_ready_in = 1; bus.wb_valid_in = 1; bus.wb_mux_sel_in = 5; bus.rd_addr_in = 3; bus.rf_wr_en_in = 1; #1;
    n_checks++; if (bus.wb_ready_out !== 1) begin n_fail++; $display("FAIL sel_ready: got %b expected 1", bus.wb_ready_out); end
    tick();
    bus.wb_valid_in = 0; rand_src(); #1;  // later source changes must not matter
    n_checks++; if (bus.rf_valid_out !== 1 || bus.rf_rd_addr_out !== 3 || bus.rf_wr_data_out !== 32'h1004 || bus.rf_wr_en_out !== 1) begin
      n_fail++; $display("FAIL sel5: got v=%b rd=%0d we=%b d=%h expected v=1 rd=3 we=1 d=00001004", bus.rf_valid_out, bus.rf_rd_addr_out, bus.rf_wr_en_out, bus.rf_wr_data_out); end
    src_w[7] = 32'h0; set_src();
    bus.wb_valid_in = 1; bus.wb_mux_sel_in = 7; bus.rd_addr_in = 4; tick();
    bus.wb_valid_in = 0; #1;
    n_checks++; if (bus.rf_rd_addr_out !== 4 || bus.rf_wr_data_out !== 32'h0) begin
      n_fail++; $display("FAIL sel7: got rd=%0d d=%h expected rd=4 d=00000000", bus.rf_rd_addr_out, bus.rf_wr_data_out); end
    rand_src(); exp_src0 = src_w[0];
    bus.wb_valid_in = 1; bus.wb_mux_sel_in = 9; bus.rd_addr_in = 6; tick();
    bus.wb_valid_in = 0; #1;
    n_checks++; if (bus.rf_rd_addr_out !== 6 || bus.rf_wr_data_out !== exp_src0) begin
      n_fail++; $display("FAIL sel9_fallback: got rd=%0d d=%h expected rd=6 d=%h", bus.rf_rd_addr_out, bus.rf_wr_data_out, exp_src0); end
    drain();
  endtask

  task automatic test_back_pressure();
    logic [31:0] d1;
    d1 = $urandom;
    bus.rf_ready_in = 0;
    push_one(1, d1); push_one(2, $urandom);
    bus.rd_addr_in = 3; bus.wb_valid_in = 1; #1;
    n_checks++; if (bus.wb_ready_out !== 0) begin n_fail++; $display("FAIL bp_ready: got %b expected 0", bus.wb_ready_out); end
    n_checks++; if (bus.count_out !== 2) begin n_fail++; $display("FAIL bp_count: got %0d expected 2", bus.count_out); end
    tick(); bus.wb_valid_in = 0; tick(); tick(); #1;
    n_checks++; if (bus.rf_rd_addr_out !== 1 || bus.rf_wr_data_out !== d1 || bus.count_out !== 2) begin
      n_fail++; $display("FAIL bp_hold: got rd=%0d d=%h cnt=%0d expected rd=1 d=%h cnt=2", bus.rf_rd_addr_out, bus.rf_wr_data_out, bus.count_out, d1); end
    bus.rf_ready_in = 1; tick(); #1;
    n_checks++; if (bus.rf_rd_addr_out !== 2 || bus.rf_wr_data_out !== m_head().data) begin
      n_fail++; $display("FAIL bp_order: got rd=%0d d=%h expected rd=2 d=%h", bus.rf_rd_addr_out, bus.rf_wr_data_out, m_head().data); end
    tick(); #1;
    n_checks++; if (bus.count_out !== 0 || bus.rf_valid_out !== 0) begin
      n_fail++; $display("FAIL bp_empty: got cnt=%0d v=%b expected cnt=0 v=0", bus.count_out, bus.rf_valid_out); end
  endtask

  task automatic test_forwarding();
    bus.rf_ready_in = 0;
    src_w[0] = 32'hAA; set_src();
    bus.wb_mux_sel_in = 0; bus.rd_addr_in = 5; bus.rf_wr_en_in = 1; bus.wb_valid_in = 1;
    bus.rs1_addr_in = 5; bus.rs2_addr_in = 0; #1;
    n_checks++; if (bus.fwd1_hit_out !== 0 || bus.fwd1_data_out !== 0) begin
      n_fail++; $display("FAIL fwd_incoming: got hit=%b d=%h expected hit=0 d=0", bus.fwd1_hit_out, bus.fwd1_data_out); end
    tick(); push_one(5, 32'hBB); #1;
    n_checks++; if (bus.fwd1_hit_out !== 1 || bus.fwd1_data_out !== 32'hBB) begin
      n_fail++; $display("FAIL fwd_youngest: got hit=%b d=%h expected hit=1 d=000000bb", bus.fwd1_hit_out, bus.fwd1_data_out); end
    n_checks++; if (bus.fwd2_hit_out !== 0 || bus.fwd2_data_out !== 0) begin
      n_fail++; $display("FAIL fwd_rs0: got hit=%b d=%h expected hit=0 d=0", bus.fwd2_hit_out, bus.fwd2_data_out); end
    drain(); bus.rf_ready_in = 0;
    push_one(0, 32'h77); #1;
    n_checks++; if (bus.rf_valid_out !== 1 || bus.rf_wr_en_out !== 0 || bus.rf_wr_data_out !== 0 || bus.fwd2_hit_out !== 0) begin
      n_fail++; $display("FAIL fwd_x0: got v=%b we=%b d=%h hit2=%b expected v=1 we=0 d=0 hit2=0", bus.rf_valid_out, bus.rf_wr_en_out, bus.rf_wr_data_out, bus.fwd2_hit_out); end
    n_checks++; if (bus.fwd1_hit_out !== 0 || bus.fwd1_data_out !== 0) begin
      n_fail++; $display("FAIL fwd_miss: got hit=%b d=%h expected hit=0 d=0", bus.fwd1_hit_out, bus.fwd1_data_out); end
    drain();
  endtask

  task automatic test_full_random();
    logic [32:0] f1, f2;
    ent_t        h;
    bus.rf_ready_in = 0;
    push_one(8, $urandom); push_one(9, $urandom);
    bus.rf_ready_in = 1; bus.wb_valid_in = 1; bus.rd_addr_in = 10; #1;
    n_checks++; if (bus.wb_ready_out !== 1) begin n_fail++; $display("FAIL full_ready: got %b expected 1", bus.wb_ready_out); end
    tick(); bus.wb_valid_in = 0; #1;
    n_checks++; if (bus.count_out !== 2 || bus.rf_rd_addr_out !== 9) begin
      n_fail++; $display("FAIL full_simul: got cnt=%0d rd=%0d expected cnt=2 rd=9", bus.count_out, bus.rf_rd_addr_out); end
    for (int cyc = 0; cyc < 100; cyc++) begin
      rand_src();
      bus.wb_valid_in   = ($urandom_range(0, 3) != 0);
      bus.wb_mux_sel_in = SEL_W'($urandom_range(0, 15));
      bus.rd_addr_in    = 5'($urandom_range(0, 6));
      bus.rf_wr_en_in   = ($urandom_range(0, 4) != 0);
      bus.rf_ready_in   = ($urandom_range(0, 2) != 0);
      bus.flush_in      = ($urandom_range(0, 15) == 0);
      bus.rs1_addr_in   = 5'($urandom_range(0, 6));
      bus.rs2_addr_in   = 5'($urandom_range(0, 6));
      #1;
      h = m_head(); f1 = m_fwd(bus.rs1_addr_in); f2 = m_fwd(bus.rs2_addr_in);
      n_checks++; if (bus.wb_ready_out !== m_ready() || bus.count_out !== mq.size()) begin
        n_fail++; $display("FAIL rnd_status cyc%0d: got rdy=%b cnt=%0d expected rdy=%b cnt=%0d", cyc, bus.wb_ready_out, bus.count_out, m_ready(), mq.size()); end
      n_checks++; if (bus.rf_valid_out !== (mq.size() != 0) || bus.rf_rd_addr_out !== h.rd || bus.rf_wr_en_out !== h.we || bus.rf_wr_data_out !== h.data) begin
        n_fail++; $display("FAIL rnd_head cyc%0d: got v=%b rd=%0d we=%b d=%h expected v=%b rd=%0d we=%b d=%h", cyc, bus.rf_valid_out, bus.rf_rd_addr_out, bus.rf_wr_en_out, bus.rf_wr_data_out, mq.size() != 0, h.rd, h.we, h.data); end
      n_checks++; if ({bus.fwd1_hit_out, bus.fwd1_data_out} !== f1 || {bus.fwd2_hit_out, bus.fwd2_data_out} !== f2) begin
        n_fail++; $display("FAIL rnd_fwd cyc%0d: got %h/%h expected %h/%h", cyc, {bus.fwd1_hit_out, bus.fwd1_data_out}, {bus.fwd2_hit_out, bus.fwd2_data_out}, f1, f2); end
      tick();
    end
    bus.flush_in = 0;
    drain();
  endtask

  task automatic test_flush_reset();
    bus.rf_ready_in = 0;
    push_one(11, $urandom); push_one(12, $urandom);
    bus.flush_in = 1; bus.wb_valid_in = 1; bus.rd_addr_in = 13; #1;
    n_checks++; if (bus.wb_ready_out !== 0) begin n_fail++; $display("FAIL flush_ready: got %b expected 0", bus.wb_ready_out); end
    tick(); bus.flush_in = 0; bus.wb_valid_in = 0; #1;
    n_checks++; if (bus.count_out !== 0 || bus.rf_valid_out !== 0) begin
      n_fail++; $display("FAIL flush_clear: got cnt=%0d v=%b expected cnt=0 v=0", bus.count_out, bus.rf_valid_out); end
    push_one(14, $urandom); push_one(15, $urandom);
    rst_n = 0; tick(); rst_n = 1; #1;
    n_checks++; if (bus.count_out !== 0 || bus.rf_valid_out !== 0 || bus.rf_wr_data_out !== 0) begin
      n_fail++; $display("FAIL reset_mid: got cnt=%0d v=%b d=%h expected cnt=0 v=0 d=0", bus.count_out, bus.rf_valid_out, bus.rf_wr_data_out); end
  endtask

  initial begin
    bus.wb_src_bus_in = '0;
    idle_inputs();
    test_reset();
    test_select();
    test_back_pressure();
    test_forwarding();
    test_full_random();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
